// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the video timing generator.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package vga_timing_pkg;

  // 640x480@60 reference timing, pixel ticks / lines
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Per-position attributes carried down the delay line
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vid_attr_t;

  // Pad level of a sync line while it is not asserted
  function automatic logic sync_idle(input logic pol);
    return ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video bundle between the timing generator and the pattern generator / pads.
// Latency: n/a (wires only).
// Backpressure: none; the master free-runs and the slave must keep up.
interface vga_timing_gen_if #(
  parameter int HW       = 10,
  parameter int VW       = 10,
  parameter int RGB_BITS = 3
);
  logic [HW-1:0]       hpos;
  logic [VW-1:0]       vpos;
  logic                pix_tick;
  logic                line_start;
  logic                frame_start;
  logic                hsync;
  logic                vsync;
  logic                de;
  logic [RGB_BITS-1:0] rgb_in;
  logic [RGB_BITS-1:0] rgb_out;

  modport master (
    output hpos, vpos, pix_tick, line_start, frame_start,
    output hsync, vsync, de, rgb_out,
    input  rgb_in
  );

  modport slave (
    input  hpos, vpos, pix_tick, line_start, frame_start,
    input  hsync, vsync, de, rgb_out,
    output rgb_in
  );
endinterface

// File: rtl/pix_clk_div.sv
// Pixel clock divider: one-clk pix_tick every CLK_DIV clk cycles.
// Latency: first tick CLK_DIV-1 cycles after clear drops (same cycle when CLK_DIV=1).
// Backpressure: none; clear holds the count at zero and suppresses the tick.
module pix_clk_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic clear,
  output logic pix_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0..CLK_DIV-1, tick on the last value
  always_comb begin
    cnt_d    = cnt_q;
    pix_tick = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d    = '0;
      pix_tick = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register; clear already folds in reset
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: hsync/vsync/de for any resolution, pixel divider, colour realignment.
// Latency: sync/de/rgb_out for position p appear PIPE_DEPTH+1 ticks after hpos/vpos show p.
// Backpressure: none; free-runs while enable=1, held idle at (0,0) while enable=0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int CLK_DIV    = 1,
  parameter int PIPE_DEPTH = 0,
  parameter int RGB_BITS   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  vga_timing_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PD1     = (PIPE_DEPTH > 0) ? PIPE_DEPTH : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic                 tick;
  logic [HW-1:0]        hcnt_q, hcnt_d;
  logic [VW-1:0]        vcnt_q, vcnt_d;
  vid_attr_t [PD1-1:0]  pipe_q, pipe_d;
  vid_attr_t            attr_raw, attr_last;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 de_q, de_d;
  logic [RGB_BITS-1:0]  rgb_out_q, rgb_out_d;
  logic                 line_start_q, line_start_d;
  logic                 frame_start_q, frame_start_d;

  // Divider is held cleared whenever the timing is not running
  pix_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (clk),
    .clear    (reset | ~enable),
    .pix_tick (tick)
  );

  // Next-state for counters, delay line, strobes and pad registers
  always_comb begin
    attr_raw.de = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    attr_raw.hs = (hcnt_q >= HS_BEGIN) && (hcnt_q < HS_END);
    attr_raw.vs = (vcnt_q >= VS_BEGIN) && (vcnt_q < VS_END);
    attr_last   = (PIPE_DEPTH == 0) ? attr_raw : pipe_q[PD1-1];

    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    pipe_d        = pipe_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    rgb_out_d     = rgb_out_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (!enable) begin
      hcnt_d    = '0;
      vcnt_d    = '0;
      pipe_d    = '0;
      hsync_d   = sync_idle(HSYNC_POL);
      vsync_d   = sync_idle(VSYNC_POL);
      de_d      = 1'b0;
      rgb_out_d = '0;
    end else if (tick) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d       = '0;
        vcnt_d       = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        line_start_d = 1'b1;
        frame_start_d = (vcnt_q == V_LAST);
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end

      pipe_d[0] = attr_raw;
      for (int i = 1; i < PD1; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end

      hsync_d   = attr_last.hs ^ sync_idle(HSYNC_POL);
      vsync_d   = attr_last.vs ^ sync_idle(VSYNC_POL);
      de_d      = attr_last.de;
      rgb_out_d = attr_last.de ? vid.rgb_in : '0;
    end
  end

  // State registers with synchronous reset to the idle picture
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pipe_q        <= '0;
      hsync_q       <= sync_idle(HSYNC_POL);
      vsync_q       <= sync_idle(VSYNC_POL);
      de_q          <= 1'b0;
      rgb_out_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pipe_q        <= pipe_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      rgb_out_q     <= rgb_out_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.hpos        = hcnt_q;
  assign vid.vpos        = vcnt_q;
  assign vid.pix_tick    = tick;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.rgb_out     = rgb_out_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: several parameterisations on one clock.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_timing_gen;

  // Small-timing instance geometry used by the vector table
  localparam int S_HA = 4, S_HF = 1, S_HS = 1, S_HB = 1;
  localparam int S_VA = 2, S_VF = 1, S_VS = 1, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int NV   = 120;
  localparam int BOUND = 20000;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] rgb;
    int         hpos;
    int         vpos;
    logic       hs;
    logic       vs;
    logic       de;
    logic [2:0] rgb_o;
    logic       ls;
    logic       fs;
  } vec_t;

  logic clk;
  logic rst0, rst_b, rst4, en4, en_on;
  int   n_vec, n_err;

  vga_timing_gen_if #(.HW(10), .VW(10), .RGB_BITS(3)) if0 ();
  vga_timing_gen_if #(.HW(10), .VW(10), .RGB_BITS(3)) if1 ();
  vga_timing_gen_if #(.HW(10), .VW(10), .RGB_BITS(3)) if2 ();
  vga_timing_gen_if #(.HW(10), .VW(3),  .RGB_BITS(3)) if3 ();
  vga_timing_gen_if #(.HW(3),  .VW(3),  .RGB_BITS(3)) if4 ();

  vga_timing_gen u0 (.clk(clk), .reset(rst0), .enable(en_on), .vid(if0));
  vga_timing_gen #(.CLK_DIV(2)) u1 (.clk(clk), .reset(rst_b), .enable(en_on), .vid(if1));
  vga_timing_gen #(.PIPE_DEPTH(2)) u2 (.clk(clk), .reset(rst_b), .enable(en_on), .vid(if2));
  vga_timing_gen #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
                   .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1))
    u3 (.clk(clk), .reset(rst_b), .enable(en_on), .vid(if3));
  vga_timing_gen #(.H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
                   .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB))
    u4 (.clk(clk), .reset(rst4), .enable(en4), .vid(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Active level of the measured line, per selector
  function automatic logic act_of(input int sel);
    case (sel)
      0:       return ~if0.hsync;
      1:       return ~if1.hsync;
      2:       return if3.hsync;
      3:       return if3.vsync;
      4:       return if4.frame_start;
      5:       return if4.line_start;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_lvl(input int sel, input logic lvl, inout int cnt, inout bit ok);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < BOUND && !hit; i++) begin
      @(negedge clk);
      cnt++;
      if (act_of(sel) == lvl) hit = 1'b1;
    end
    if (!hit) ok = 1'b0;
  endtask

  // Width of an active pulse and activation-to-activation period, in clks
  task automatic measure(input int sel, output int width, output int period);
    int c;
    bit ok;
    ok = 1'b1;
    c  = 0;
    wait_lvl(sel, 1'b0, c, ok);
    wait_lvl(sel, 1'b1, c, ok);
    c = 0;
    wait_lvl(sel, 1'b0, c, ok);
    width = c;
    wait_lvl(sel, 1'b1, c, ok);
    period = c;
    if (!ok) begin
      width  = -1;
      period = -1;
    end
  endtask

  // Pattern generator model for the pipelined instance: colour of the
  // position shown two ticks earlier, 7 when that position is blanking
  initial begin
    int d1, d2;
    d1 = 0;
    d2 = 0;
    if2.rgb_in = 3'd0;
    forever begin
      @(negedge clk);
      if2.rgb_in = (d2 >= 640) ? 3'd7 : 3'(d2);
      d2 = d1;
      d1 = int'(if2.hpos);
    end
  end

  initial begin
    vec_t vecs [NV];
    vec_t q [$];
    vec_t e;
    int   mh, mv, w, p, n;
    bit   found;

    n_vec = 0;
    n_err = 0;
    en_on = 1'b1;
    rst0  = 1'b1;
    rst_b = 1'b1;
    rst4  = 1'b1;
    en4   = 1'b1;
    if0.rgb_in = 3'd0;
    if1.rgb_in = 3'd0;
    if3.rgb_in = 3'd0;
    if4.rgb_in = 3'd0;

    // Vector table for the small instance, expected values from a position model
    mh = 0;
    mv = 0;
    for (int i = 0; i < NV; i++) begin
      vecs[i].rst = (i < 2) || (i == 80);
      vecs[i].en  = !(i >= 40 && i < 43) && (i != 1);
      vecs[i].rgb = 3'($urandom_range(0, 7));
      if (vecs[i].rst || !vecs[i].en) begin
        mh = 0;
        mv = 0;
        vecs[i].hs    = 1'b1;
        vecs[i].vs    = 1'b1;
        vecs[i].de    = 1'b0;
        vecs[i].rgb_o = 3'd0;
        vecs[i].ls    = 1'b0;
        vecs[i].fs    = 1'b0;
      end else begin
        vecs[i].de    = (mh < S_HA) && (mv < S_VA);
        vecs[i].hs    = !((mh >= S_HA + S_HF) && (mh < S_HA + S_HF + S_HS));
        vecs[i].vs    = !((mv >= S_VA + S_VF) && (mv < S_VA + S_VF + S_VS));
        vecs[i].rgb_o = vecs[i].de ? vecs[i].rgb : 3'd0;
        vecs[i].ls    = (mh == S_HT - 1);
        vecs[i].fs    = (mh == S_HT - 1) && (mv == S_VT - 1);
        if (mh == S_HT - 1) begin
          mh = 0;
          mv = (mv == S_VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
      vecs[i].hpos = mh;
      vecs[i].vpos = mv;
    end

    // Idle state while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hpos",  if0.hpos, 0);
    chk("rst_vpos",  if0.vpos, 0);
    chk("rst_hsync", if0.hsync, 1);
    chk("rst_vsync", if0.vsync, 1);
    chk("rst_de",    if0.de, 0);
    chk("rst_rgb",   if0.rgb_out, 0);
    chk("rst_tick",  if0.pix_tick, 0);
    chk("rst_ls",    if0.line_start, 0);
    chk("rst_fs",    if0.frame_start, 0);
    chk("rst_hsync_pol1", if3.hsync, 0);
    chk("rst_vsync_pol1", if3.vsync, 0);

    @(negedge clk);
    rst0  = 1'b0;
    rst_b = 1'b0;

    fork
      // Pipelined instance: first de after PIPE_DEPTH+1 ticks, colour realigned
      begin
        int k, pos;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
          @(negedge clk);
          #1;
          n++;
          if (if2.de) found = 1'b1;
        end
        chk("pipe_first_de_cycle", found ? n : -1, 3);
        chk("pipe_first_rgb", if2.rgb_out, 0);
        for (k = 1; k <= 800; k++) begin
          @(negedge clk);
          #1;
          pos = k % 800;
          chk("pipe_de", if2.de, (pos < 640) ? 1 : 0);
          chk("pipe_rgb", if2.rgb_out, (pos < 640) ? (pos % 8) : 0);
        end
      end
      // Divide-by-2 instance: alternating tick, each hpos held 2 clks
      begin
        for (int k = 0; k < 20; k++) begin
          if (k > 0) @(negedge clk);
          #1;
          chk("div2_tick", if1.pix_tick, k % 2);
          chk("div2_hpos", if1.hpos, k / 2);
        end
      end
      // Small instance: table through scoreboard
      begin
        for (int i = 0; i < NV; i++) begin
          rst4 = vecs[i].rst;
          en4  = vecs[i].en;
          if4.rgb_in = vecs[i].rgb;
          q.push_back(vecs[i]);
          #1;
          chk("tbl_tick", if4.pix_tick, (vecs[i].en && !vecs[i].rst) ? 1 : 0);
          @(posedge clk);
          #1;
          e = q.pop_front();
          chk("tbl_hpos",  if4.hpos, e.hpos);
          chk("tbl_vpos",  if4.vpos, e.vpos);
          chk("tbl_hsync", if4.hsync, e.hs);
          chk("tbl_vsync", if4.vsync, e.vs);
          chk("tbl_de",    if4.de, e.de);
          chk("tbl_rgb",   if4.rgb_out, e.rgb_o);
          chk("tbl_ls",    if4.line_start, e.ls);
          chk("tbl_fs",    if4.frame_start, e.fs);
          @(negedge clk);
        end
      end
    join

    // Sync pulse widths and periods
    measure(0, w, p);
    chk("def_hsync_low", w, 96);
    chk("def_hsync_period", p, 800);
    measure(1, w, p);
    chk("div2_hsync_low", w, 192);
    chk("div2_hsync_period", p, 1600);
    measure(2, w, p);
    chk("pol1_hsync_high", w, 96);
    chk("pol1_hsync_period", p, 800);
    measure(3, w, p);
    chk("pol1_vsync_high", w, 1600);
    chk("pol1_vsync_period", p, 6400);

    // Strobe spacing on the small instance
    measure(4, w, p);
    chk("small_fs_width", w, 1);
    chk("small_fs_period", p, S_HT * S_VT);
    measure(5, w, p);
    chk("small_ls_width", w, 1);
    chk("small_ls_period", p, S_HT);

    // One-clk reset mid-line at column 300
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (if0.hpos == 10'd300) found = 1'b1;
    end
    chk("midrst_reach_300", found, 1);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_hpos",  if0.hpos, 0);
    chk("midrst_vpos",  if0.vpos, 0);
    chk("midrst_de",    if0.de, 0);
    chk("midrst_hsync", if0.hsync, 1);
    chk("midrst_ls",    if0.line_start, 0);
    chk("midrst_fs",    if0.frame_start, 0);
    @(negedge clk);
    rst0 = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_next_hpos", if0.hpos, 1);
    chk("midrst_next_ls",   if0.line_start, 0);
    chk("midrst_next_fs",   if0.frame_start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
